timed_traffic_light_controller: RTL and testbench

//  Highway/farm-road intersection controller with a parameterised time base. Adds minimum
//  and maximum green times, timed yellows and an all-red clearance interval.
//  The farm sensor is synchronised and latched as a request. Sits between the sensor

---
 rtl/timed_traffic_light_controller.sv | 167 ++++++++++++++++
 tb/tb_timed_traffic_light_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timed_traffic_light_controller.sv
// Highway/farm-road traffic light controller with tick-based minimum/maximum greens,
// timed yellows and all-red clearance. Define FLASH_MODE_EN to add the flashing mode.
module timed_traffic_light_controller #(
  parameter int CNT_W     = 16,
  parameter int T_HWY_MIN = 20,
  parameter int T_YELLOW  = 4,
  parameter int T_ALLRED  = 2,
  parameter int T_FWY_MIN = 5,
  parameter int T_FWY_MAX = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       farm_sensor_X,
`ifdef FLASH_MODE_EN
  input  logic       flash_mode,
`endif
  output logic [1:0] hwy_TL,
  output logic [1:0] fwy_TL,
  output logic [2:0] state_o
);

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
`ifdef FLASH_MODE_EN
  localparam logic [1:0] DARK   = 2'b11;
`endif

  // A zero duration behaves as one tick; the farm max never undercuts the farm min.
  localparam int HWY_N  = (T_HWY_MIN < 1) ? 1 : T_HWY_MIN;
  localparam int YEL_N  = (T_YELLOW  < 1) ? 1 : T_YELLOW;
  localparam int AR_N   = (T_ALLRED  < 1) ? 1 : T_ALLRED;
  localparam int FMIN_N = (T_FWY_MIN < 1) ? 1 : T_FWY_MIN;
  localparam int FMAX_R = (T_FWY_MAX < 1) ? 1 : T_FWY_MAX;
  localparam int FMAX_N = (FMAX_R < FMIN_N) ? FMIN_N : FMAX_R;

  localparam logic [CNT_W-1:0] HWY_LAST  = CNT_W'(HWY_N - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL_N - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(AR_N - 1);
  localparam logic [CNT_W-1:0] FMIN_LAST = CNT_W'(FMIN_N - 1);
  localparam logic [CNT_W-1:0] FMAX_LAST = CNT_W'(FMAX_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    HWY_G = 3'd0, HWY_Y = 3'd1, AR1 = 3'd2, FWY_G = 3'd3,
    FWY_Y = 3'd4, AR2 = 3'd5, FLASH = 3'd6
  } state_t;

  state_t           state_q, state_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [1:0]       sens_sync_q, sens_sync_d;
  logic [1:0]       hwy_tl_q, hwy_tl_d, fwy_tl_q, fwy_tl_d;
  logic             sx, illegal;
`ifdef FLASH_MODE_EN
  logic [1:0]       flash_sync_q, flash_sync_d;
  logic             phase_q, phase_d, sf;
`endif

  assign sx = sens_sync_q[1];
`ifdef FLASH_MODE_EN
  assign sf = flash_sync_q[1];
`endif

  always_comb begin
    sens_sync_d = {sens_sync_q[0], farm_sensor_X};
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    nxt         = state_q;
    illegal     = 1'b0;
    hwy_tl_d    = RED;
    fwy_tl_d    = RED;
`ifdef FLASH_MODE_EN
    flash_sync_d = {flash_sync_q[0], flash_mode};
    phase_d      = phase_q;
`endif

    if (sx && (state_q inside {HWY_G, HWY_Y, AR1})) req_d = 1'b1;

    case (state_q)
      HWY_G: if (req_q && cnt_q >= HWY_LAST) nxt = HWY_Y;
      HWY_Y: if (cnt_q >= YEL_LAST) nxt = AR1;
      AR1:   if (cnt_q >= AR_LAST) nxt = FWY_G;
      FWY_G: if (cnt_q >= FMAX_LAST || (cnt_q >= FMIN_LAST && !sx)) nxt = FWY_Y;
      FWY_Y: if (cnt_q >= YEL_LAST) nxt = AR2;
      AR2:   if (cnt_q >= AR_LAST) nxt = HWY_G;
`ifdef FLASH_MODE_EN
      FLASH: if (!sf) nxt = AR2;
`endif
      default: illegal = 1'b1;
    endcase

`ifdef FLASH_MODE_EN
    if (sf && !illegal && state_q != FLASH) nxt = FLASH;
`endif

    // Illegal codes recover regardless of tick; everything else moves only on tick.
    if (illegal) begin
      state_d = HWY_G;
      cnt_d   = '0;
`ifdef FLASH_MODE_EN
      phase_d = 1'b0;
`endif
    end else if (tick) begin
      state_d = nxt;
      if (nxt != state_q) begin
        cnt_d = '0;
        if (nxt == FWY_G || nxt == FLASH) req_d = 1'b0;
`ifdef FLASH_MODE_EN
        phase_d = 1'b0;
`endif
      end else begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef FLASH_MODE_EN
        phase_d = (state_q == FLASH) ? ~phase_q : 1'b0;
`endif
      end
    end

    case (state_d)
      HWY_G: hwy_tl_d = GREEN;
      HWY_Y: hwy_tl_d = YELLOW;
      FWY_G: fwy_tl_d = GREEN;
      FWY_Y: fwy_tl_d = YELLOW;
`ifdef FLASH_MODE_EN
      FLASH: begin
        hwy_tl_d = phase_d ? RED  : YELLOW;
        fwy_tl_d = phase_d ? DARK : RED;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HWY_G;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      sens_sync_q  <= '0;
      hwy_tl_q     <= GREEN;
      fwy_tl_q     <= RED;
`ifdef FLASH_MODE_EN
      flash_sync_q <= '0;
      phase_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      sens_sync_q  <= sens_sync_d;
      hwy_tl_q     <= hwy_tl_d;
      fwy_tl_q     <= fwy_tl_d;
`ifdef FLASH_MODE_EN
      flash_sync_q <= flash_sync_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign hwy_TL  = hwy_tl_q;
  assign fwy_TL  = fwy_tl_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_timed_traffic_light_controller.sv
// Directed bench for timed_traffic_light_controller with short timings
// (HWY_MIN=5 YELLOW=3 ALLRED=1 FWY_MIN=2 FWY_MAX=6, CNT_W=4).
module tb_timed_traffic_light_controller;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       farm_sensor_X;
`ifdef FLASH_MODE_EN
  logic       flash_mode;
`endif
  logic [1:0] hwy_TL;
  logic [1:0] fwy_TL;
  logic [2:0] state_o;

  int vectors;
  int miscompares;

  timed_traffic_light_controller #(
    .CNT_W(4), .T_HWY_MIN(5), .T_YELLOW(3), .T_ALLRED(1), .T_FWY_MIN(2), .T_FWY_MAX(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .farm_sensor_X(farm_sensor_X),
`ifdef FLASH_MODE_EN
    .flash_mode(flash_mode),
`endif
    .hwy_TL(hwy_TL),
    .fwy_TL(fwy_TL),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {hwy, fwy} lamps for each non-flash state code.
  function automatic logic [3:0] lamps(input logic [2:0] s);
    case (s)
      3'd0:    lamps = 4'b10_00;
      3'd1:    lamps = 4'b01_00;
      3'd3:    lamps = 4'b00_10;
      3'd4:    lamps = 4'b00_01;
      default: lamps = 4'b00_00;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] want;
    rst_n = 1'b1;
    tick = 1'b1;
    farm_sensor_X = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    want = {3'd0, lamps(3'd0)};
    vectors++;
    if ({state_o, hwy_TL, fwy_TL} !== want) begin
      miscompares++;
      $display("FAIL reset_async: got state=%0d hwy=%b fwy=%b, want state=0 hwy=10 fwy=00",
               state_o, hwy_TL, fwy_TL);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      vectors++;
      if ({state_o, hwy_TL, fwy_TL} !== want) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: got state=%0d hwy=%b fwy=%b, want state=0 hwy=10 fwy=00",
                 i, state_o, hwy_TL, fwy_TL);
      end
    end
    $display("test_reset done: %0d vectors, %0d miscompares so far", vectors, miscompares);
  endtask

  task automatic test_sensor_pulse();
    logic [2:0] exp [20] = '{0,0,0,1,1,1,2,3,3,4,4,4,5,0,0,0,0,0,0,0};
    farm_sensor_X = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      farm_sensor_X = 1'b0;
      vectors++;
      if ({state_o, hwy_TL, fwy_TL} !== {exp[i], lamps(exp[i])}) begin
        miscompares++;
        $display("FAIL pulse_seq[%0d]: got state=%0d hwy=%b fwy=%b, want state=%0d lamps=%b",
                 i, state_o, hwy_TL, fwy_TL, exp[i], lamps(exp[i]));
      end
    end
    $display("test_sensor_pulse done: %0d vectors, %0d miscompares so far", vectors, miscompares);
  endtask

  task automatic test_max_green();
    logic [2:0] exp [23] = '{0,0,0,1,1,1,2,3,3,3,3,3,3,4,4,4,5,0,0,0,0,0,1};
    farm_sensor_X = 1'b1;
    for (int i = 0; i < 23; i++) begin
      step();
      vectors++;
      if ({state_o, hwy_TL, fwy_TL} !== {exp[i], lamps(exp[i])}) begin
        miscompares++;
        $display("FAIL maxgreen_seq[%0d]: got state=%0d hwy=%b fwy=%b, want state=%0d lamps=%b",
                 i, state_o, hwy_TL, fwy_TL, exp[i], lamps(exp[i]));
      end
    end
    farm_sensor_X = 1'b0;
    $display("test_max_green done: %0d vectors, %0d miscompares so far", vectors, miscompares);
  endtask

  task automatic test_tick_gating();
    logic [2:0] want;
    int         n;
    n = 0;
    while (state_o !== 3'd4 && n < 40) begin
      step();
      n++;
    end
    vectors++;
    if (state_o !== 3'd4) begin
      miscompares++;
      $display("FAIL gate_reach_fwy_y: got state=%0d after %0d clk, want state=4", state_o, n);
    end
    for (int k = 1; k <= 12; k++) begin
      tick = (k % 4 == 0);
      step();
      want = (k < 12) ? 3'd4 : 3'd5;
      vectors++;
      if ({state_o, hwy_TL, fwy_TL} !== {want, lamps(want)}) begin
        miscompares++;
        $display("FAIL gate_hold[%0d]: got state=%0d hwy=%b fwy=%b, want state=%0d lamps=%b",
                 k, state_o, hwy_TL, fwy_TL, want, lamps(want));
      end
    end
    tick = 1'b1;
    step();
    vectors++;
    if ({state_o, hwy_TL, fwy_TL} !== {3'd0, lamps(3'd0)}) begin
      miscompares++;
      $display("FAIL gate_exit: got state=%0d hwy=%b fwy=%b, want state=0 hwy=10 fwy=00",
               state_o, hwy_TL, fwy_TL);
    end
    $display("test_tick_gating done: %0d vectors, %0d miscompares so far", vectors, miscompares);
  endtask

  task automatic test_async_reset();
    logic [2:0] exp [5] = '{0,0,0,0,1};
    int         n;
    farm_sensor_X = 1'b1;
    n = 0;
    while (state_o !== 3'd3 && n < 40) begin
      step();
      n++;
    end
    step();
    vectors++;
    if ({state_o, dut.cnt_q} !== {3'd3, 4'd1}) begin
      miscompares++;
      $display("FAIL arst_pre: got state=%0d cnt=%0d, want state=3 cnt=1", state_o, dut.cnt_q);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({state_o, hwy_TL, fwy_TL, dut.req_q, dut.cnt_q} !== {3'd0, 4'b10_00, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL arst_immediate: got state=%0d hwy=%b fwy=%b req=%b cnt=%0d, want 0/10/00/0/0",
               state_o, hwy_TL, fwy_TL, dut.req_q, dut.cnt_q);
    end
    step();
    vectors++;
    if ({state_o, hwy_TL, fwy_TL} !== {3'd0, 4'b10_00}) begin
      miscompares++;
      $display("FAIL arst_hold: got state=%0d hwy=%b fwy=%b, want state=0 hwy=10 fwy=00",
               state_o, hwy_TL, fwy_TL);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({state_o, hwy_TL, fwy_TL} !== {exp[i], lamps(exp[i])}) begin
        miscompares++;
        $display("FAIL arst_min_green[%0d]: got state=%0d hwy=%b fwy=%b, want state=%0d lamps=%b",
                 i, state_o, hwy_TL, fwy_TL, exp[i], lamps(exp[i]));
      end
    end
    farm_sensor_X = 1'b0;
    $display("test_async_reset done: %0d vectors, %0d miscompares so far", vectors, miscompares);
  endtask

`ifdef FLASH_MODE_EN
  task automatic test_flash();
    logic [6:0] exp [10] = '{7'b000_1000, 7'b000_1000, 7'b110_0100, 7'b110_0011, 7'b110_0100,
                             7'b110_0011, 7'b110_0100, 7'b110_0011, 7'b101_0000, 7'b000_1000};
    int         n;
    n = 0;
    while (state_o !== 3'd0 && n < 60) begin
      step();
      n++;
    end
    vectors++;
    if (state_o !== 3'd0) begin
      miscompares++;
      $display("FAIL flash_reach_hwy_g: got state=%0d after %0d clk, want state=0", state_o, n);
    end
    flash_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 5) flash_mode = 1'b0;
      vectors++;
      if ({state_o, hwy_TL, fwy_TL} !== exp[i]) begin
        miscompares++;
        $display("FAIL flash_seq[%0d]: got state=%0d hwy=%b fwy=%b, want state=%0d hwy=%b fwy=%b",
                 i, state_o, hwy_TL, fwy_TL, exp[i][6:4], exp[i][3:2], exp[i][1:0]);
      end
    end
    $display("test_flash done: %0d vectors, %0d miscompares so far", vectors, miscompares);
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
`ifdef FLASH_MODE_EN
    flash_mode = 1'b0;
`endif
    test_reset();
    test_sensor_pulse();
    test_max_green();
    test_tick_gating();
    test_async_reset();
`ifdef FLASH_MODE_EN
    test_flash();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
